// File: rtl/sum_pkg.sv
// Shared types and default widths for the sample-sum collector.
package sum_pkg;

  localparam int unsigned SUM_DW = 5;
  localparam int unsigned SUM_AW = 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum bit [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/sum_acc.sv
// Accumulator/peak/overflow datapath for one sample group.
// SUM_COLLECT_SAT_EN: clamp the accumulator at full scale instead of wrapping.
module sum_acc
  import sum_pkg::*;
#(
  parameter int unsigned DW = SUM_DW,
  parameter int unsigned AW = SUM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          load,
  input  logic          add,
  input  logic [DW-1:0] data,
  output logic [AW-1:0] sum_c,
  output logic [DW-1:0] peak_c,
  output logic          ovf_c
);

  logic [AW-1:0] acc, acc_nxt;
  logic [DW-1:0] peak, peak_nxt;
  logic          ovf, ovf_nxt;
  logic [AW:0]   sum_ext;
  logic          carry;

  assign sum_ext = {1'b0, acc} + (AW+1)'(data);
  assign carry   = sum_ext[AW];

  always_comb begin
    acc_nxt  = acc;
    peak_nxt = peak;
    ovf_nxt  = ovf;
    if (clear) begin
      acc_nxt  = '0;
      peak_nxt = '0;
      ovf_nxt  = 1'b0;
    end else if (load) begin
      acc_nxt  = AW'(data);
      peak_nxt = data;
      ovf_nxt  = 1'b0;
    end else if (add) begin
      ovf_nxt = ovf | carry;
`ifdef SUM_COLLECT_SAT_EN
      // once saturated, the group total stays pinned at full scale
      acc_nxt = (ovf | carry) ? {AW{1'b1}} : sum_ext[AW-1:0];
`else
      acc_nxt = sum_ext[AW-1:0];
`endif
      if (data > peak) peak_nxt = data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      peak <= '0;
      ovf  <= 1'b0;
    end else begin
      acc  <= acc_nxt;
      peak <= peak_nxt;
      ovf  <= ovf_nxt;
    end
  end

  assign sum_c  = acc_nxt;
  assign peak_c = peak_nxt;
  assign ovf_c  = ovf_nxt;

endmodule

// File: rtl/sum_collect.sv
// Collects NSAMP upstream samples into a sum/peak/overflow result and holds it
// until the downstream accepts it. Build option: SUM_COLLECT_SAT_EN (saturate).
module sum_collect
  import sum_pkg::*;
#(
  parameter int unsigned NSAMP = 4,
  parameter int unsigned DW    = SUM_DW,
  parameter int unsigned AW    = SUM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic [DW-1:0] out_peak,
  output logic          out_ovf
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept;
  logic             load, add, capture;
  logic [AW-1:0]    sum_c;
  logic [DW-1:0]    peak_c;
  logic             ovf_c;

  // handshake decoded purely from the registered state
  assign in_ready  = (state == IDLE) || (state == ACC);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    add       = 1'b0;
    capture   = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          load    = 1'b1;
          cnt_nxt = CNT_W'(1);
          if (NSAMP == 1) begin
            state_nxt = HOLD;
            capture   = 1'b1;
          end else begin
            state_nxt = ACC;
          end
        end
        ACC: if (accept) begin
          add     = 1'b1;
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt + CNT_W'(1) == CNT_W'(NSAMP)) begin
            state_nxt = HOLD;
            capture   = 1'b1;
          end
        end
        HOLD: if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  sum_acc #(
    .DW (DW),
    .AW (AW)
  ) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .load   (load),
    .add    (add),
    .data   (in_data),
    .sum_c  (sum_c),
    .peak_c (peak_c),
    .ovf_c  (ovf_c)
  );

  // result registers: loaded on the final accept, retained until the next group
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum  <= '0;
      out_peak <= '0;
      out_ovf  <= 1'b0;
    end else if (capture) begin
      out_sum  <= sum_c;
      out_peak <= peak_c;
      out_ovf  <= ovf_c;
    end
  end

endmodule

// File: tb/tb_sum_collect.sv
// Randomized + directed bench for sum_collect against a group-level reference model.
module tb_sum_collect;

  localparam int NS   = 4;
  localparam int MAXV = 255;
`ifdef SUM_COLLECT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] in_data = '0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, out_ovf;
  logic [7:0] out_sum;
  logic [4:0] out_peak;

  logic       v16 = 1'b0;
  logic [4:0] d16 = '0;
  logic       r16 = 1'b0;
  logic       rdy16, ov16, o16;
  logic [7:0] s16;
  logic [4:0] p16;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sum_collect #(.NSAMP(NS), .DW(5), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_peak(out_peak), .out_ovf(out_ovf)
  );

  sum_collect #(.NSAMP(16), .DW(5), .AW(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .clear(1'b0), .in_valid(v16), .in_data(d16),
    .in_ready(rdy16), .out_valid(ov16), .out_ready(r16),
    .out_sum(s16), .out_peak(p16), .out_ovf(o16)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // reference model: a group is the list of accepted samples; result computed from its total
  int q[$];
  bit m_hold = 1'b0;
  int m_sum = 0, m_peak = 0;
  bit m_ovf = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      m_hold = 1'b0; m_sum = 0; m_peak = 0; m_ovf = 1'b0;
    end else if (clear) begin
      q.delete();
      m_hold = 1'b0;
    end else if (m_hold) begin
      if (out_ready) m_hold = 1'b0;
    end else if (in_valid) begin
      q.push_back(int'(in_data));
      if (q.size() == NS) begin
        int tot, pk;
        tot = 0; pk = 0;
        foreach (q[i]) begin
          tot += q[i];
          if (q[i] > pk) pk = q[i];
        end
        m_ovf  = tot > MAXV;
        m_sum  = SAT ? (m_ovf ? MAXV : tot) : tot % (MAXV + 1);
        m_peak = pk;
        m_hold = 1'b1;
        q.delete();
      end
    end
  end

  int dut_results = 0;

  // compare process: every mid-cycle while out of reset
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("in_ready", int'(in_ready), m_hold ? 0 : 1);
      check("out_valid", int'(out_valid), int'(m_hold));
      check("out_sum", int'(out_sum), m_sum);
      check("out_peak", int'(out_peak), m_peak);
      check("out_ovf", int'(out_ovf), int'(m_ovf));
      if (out_valid && out_ready) dut_results++;
    end
  end

  task automatic send(input int d);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = 5'(d);
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int base;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_sum", int'(out_sum), 0);
    check("rst_out_peak", int'(out_peak), 0);
    check("rst_out_ovf", int'(out_ovf), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    cycles(1);

    // sixteen full-scale samples on the NSAMP=16 instance
    v16 = 1'b1; d16 = 5'd31;
    repeat (16) @(posedge clk);
    #2 v16 = 1'b0;
    check("n16_valid", int'(ov16), 1);
    check("n16_sum", int'(s16), SAT ? 255 : 240);
    check("n16_ovf", int'(o16), 1);
    check("n16_peak", int'(p16), 31);
    r16 = 1'b1;
    cycles(1);
    r16 = 1'b0;
    check("n16_release", int'(ov16), 0);

    // basic group, result held with downstream stalled
    out_ready = 1'b0;
    send(3); send(5); send(7); send(31);
    check("g1_valid", int'(out_valid), 1);
    check("g1_sum", int'(out_sum), 46);
    check("g1_peak", int'(out_peak), 31);
    check("g1_ovf", int'(out_ovf), 0);
    check("g1_model_sum", m_sum, 46);

    in_valid = 1'b1; in_data = 5'd9;
    repeat (5) begin
      cycles(1);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_sum", int'(out_sum), 46);
    end
    out_ready = 1'b1;
    cycles(1);
    in_valid = 1'b0; out_ready = 1'b0;
    check("release_idle", int'(out_valid), 0);
    check("release_ready", int'(in_ready), 1);
    check("release_retain", int'(out_sum), 46);

    // clear aborts a partial group
    out_ready = 1'b1;
    send(9); send(9);
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    send(1); send(1); send(1); send(1);
    check("clr_valid", int'(out_valid), 1);
    check("clr_sum", int'(out_sum), 4);
    check("clr_peak", int'(out_peak), 1);
    cycles(1);

    // asynchronous reset while holding a result
    out_ready = 1'b0;
    send(5); send(6); send(7); send(8);
    check("pre_rst_sum", int'(out_sum), 26);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", int'(out_valid), 0);
    check("arst_sum", int'(out_sum), 0);
    check("arst_peak", int'(out_peak), 0);
    check("arst_ovf", int'(out_ovf), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cycles(1);
    out_ready = 1'b1;
    send(2); send(2); send(2); send(2);
    check("post_rst_sum", int'(out_sum), 8);
    check("post_rst_model", m_sum, 8);
    cycles(1);

    // random gaps between samples, exactly one result
    out_ready = 1'b0;
    base = dut_results;
    for (int i = 1; i <= 4; i++) begin
      cycles($urandom_range(0, 3));
      send(i);
    end
    check("gap_sum", int'(out_sum), 10);
    check("gap_peak", int'(out_peak), 4);
    out_ready = 1'b1;
    cycles(4);
    check("gap_results", dut_results - base, 1);

    // randomized traffic with occasional aborts
    repeat (800) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 5'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 31) == 0);
      cycles(1);
    end
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sum_collect.md
SUM_COLLECT -- requirements
Module: sum_collect

Interface
REQ-001 SHALL have parameter NSAMP, default 4, number of samples per result (1..255).
REQ-002 SHALL have parameter DW, default 5, input sample width (matches adder-stage data).
REQ-003 SHALL have parameter AW, default 8, accumulator/result width (AW > DW).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clear  input  1  synchronous abort of current collection.
REQ-007 SHALL have port in_valid  input  1  upstream sample valid.
REQ-008 SHALL have port in_data  input  DW  upstream sum sample (unsigned).
REQ-009 SHALL have port in_ready  output  1  block accepts sample this cycle.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port out_sum  output  AW  accumulated total of NSAMP samples.
REQ-013 SHALL have port out_peak  output  DW  largest sample in the group.
REQ-014 SHALL have port out_ovf  output  1  accumulator exceeded 2^AW-1 during the group.

Function
REQ-015 SHALL implement 2-bit state IDLE=0, ACC=1, HOLD=2; state 3 decodes as IDLE next cycle.
REQ-016 SHALL accept a sample only when in_valid && in_ready at a rising edge.
REQ-017 SHALL drive in_ready=1 in IDLE/ACC, 0 in HOLD; decoded from registered state only.
REQ-018 IDLE: accepted sample loads acc=in_data, peak=in_data, cnt=1, ovf=0; next ACC, or HOLD if NSAMP==1.
REQ-019 ACC: accepted sample adds to acc, peak=max(peak,in_data), cnt+1; when cnt reaches NSAMP, next HOLD.
REQ-020 ACC with in_valid low SHALL hold all registers (no timeout).
REQ-021 HOLD: out_valid=1, out_sum/out_peak/out_ovf stable; out_valid rises the cycle after the NSAMP-th accept (latency 1).
REQ-022 HOLD with out_ready=1 SHALL return to IDLE next cycle; a same-cycle in_valid is not accepted (in_ready=0).
REQ-023 out_valid SHALL be 0 in IDLE/ACC; outputs retain last values until the next HOLD.
REQ-024 Carry out of bit AW-1 on any add SHALL set sticky ovf for the group.
REQ-025 clear=1 SHALL take priority over all transitions: next state IDLE, acc/peak/cnt/ovf zeroed, out_valid 0.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, cnt 0, acc 0, peak 0, ovf 0, out_valid 0, out_sum 0, out_peak 0, out_ovf 0.
REQ-027 Reset mid-ACC or mid-HOLD SHALL discard the partial/held group; first accept after release starts a new group.

Configuration
REQ-028 Macro SUM_COLLECT_SAT_EN defined: on overflow acc SHALL clamp to 2^AW-1 and stay there for the group; out_ovf set.
REQ-029 Macro undefined: acc SHALL wrap modulo 2^AW; out_ovf still set.

Structure
REQ-030 Package sum_pkg SHALL hold the state typedef (enum bit [1:0] IDLE/ACC/HOLD) and default widths SUM_DW=5, SUM_AW=8.
REQ-031 Sub-module sum_acc SHALL hold acc/peak/ovf datapath (load, add, clamp/wrap); FSM, cnt and handshake stay in sum_collect.

Verification
REQ-032 NSAMP=4, samples 3,5,7,31 back-to-back -> out_valid cycle after 4th; out_sum=46, out_peak=31, out_ovf=0.
REQ-033 NSAMP=16, sixteen samples of 31 -> macro off: out_sum=240, out_ovf=1; macro on: out_sum=255, out_ovf=1.
REQ-034 Result held, out_ready low 5 cycles, in_valid high -> in_ready 0, outputs stable, no sample consumed; out_ready high -> IDLE next cycle.
REQ-035 Two samples 9,9, clear pulse, then four samples of 1 -> out_sum=4, out_peak=1.
REQ-036 rst_n low during HOLD -> out_valid and outputs 0 asynchronously; after release, samples 2,2,2,2 -> out_sum=8.
REQ-037 in_valid gaps of 0-3 random cycles between samples 1,2,3,4 -> out_sum=10, out_peak=4, exactly one result.
